fp_prealign: RTL and testbench

- Block-floating-point pre-aligner at the CIM input side; inverse of the post-accumulation normaliser.
- Collects a block of N E5M2 operands and finds the block's maximum exponent.
- Emits each operand as a signed fixed-point integer aligned to that exponent, plus exp_max, for the CIM array and accumulator.
- In integer mode it passes operands through unchanged.

---
 rtl/cim_fp_pkg.sv | 21 ++
 rtl/fp_align_shift.sv | 27 ++
 rtl/fp_prealign.sv | 111 +++++++++++
 tb/tb_fp_prealign.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cim_fp_pkg.sv
// Shared types and widths for the CIM block-floating-point input path.
package cim_fp_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 2;
  localparam int GUARD = 4;
  localparam int MAG_W = 1 + MAN_W + GUARD;
  localparam int OUT_W = 1 + MAG_W;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] mant;
  } fp8_t;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } prealign_state_t;

endpackage

// File: rtl/fp_align_shift.sv
// Aligns one E5M2 operand to a block exponent as a signed fixed-point value.
module fp_align_shift
  import cim_fp_pkg::*;
(
  input  fp8_t                    op_i,
  input  logic [EXP_W-1:0]        exp_max_i,
  output logic signed [OUT_W-1:0] data_o
);

  logic [EXP_W-1:0] diff;
  logic [MAG_W-1:0] mag;
  logic [MAG_W-1:0] mag_sh;
  logic [OUT_W-1:0] pos;

  always_comb begin
    diff   = exp_max_i - op_i.exp;
    mag    = {1'b1, op_i.mant, {GUARD{1'b0}}};
    mag_sh = '0;
    // Denormals flush; shifts of MAG_W or more leave nothing of the mantissa.
    if (op_i.exp != '0 && diff < EXP_W'(MAG_W)) begin
      mag_sh = mag >> diff;
    end
    pos    = {1'b0, mag_sh};
    data_o = op_i.sign ? -pos : pos;
  end

endmodule

// File: rtl/fp_prealign.sv
// Block-floating-point pre-aligner: gathers N operands, finds the block max
// exponent, then streams each operand aligned to it (or raw in integer mode).
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | accepting operands into the buffer, tracking running max exp
// EMIT    | streaming aligned operands; input side stalled
module fp_prealign
  import cim_fp_pkg::*;
#(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic             InFp,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic [EXP_W-1:0] exp_max
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  prealign_state_t  state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [EXP_W-1:0] exp_max_q, exp_max_d;
  logic             mode_q, mode_d;
  logic             wr_en;
  logic [7:0]       opbuf_q [N];
  logic [7:0]       cur_op;
  fp8_t             in_op;
  logic signed [OUT_W-1:0] aligned;

  assign in_op  = fp8_t'(in_data);
  assign cur_op = opbuf_q[count_q];

  fp_align_shift u_align (
    .op_i      (fp8_t'(cur_op)),
    .exp_max_i (exp_max_q),
    .data_o    (aligned)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    exp_max_d = exp_max_q;
    mode_d    = mode_q;
    wr_en     = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (in_valid) begin
          wr_en   = 1'b1;
          count_d = count_q + CNT_W'(1);
          if (count_q == '0) begin
            mode_d    = InFp;
            exp_max_d = in_op.exp;
          end else if (in_op.exp != '0 && in_op.exp > exp_max_q) begin
            exp_max_d = in_op.exp;
          end
          if (count_q == LAST) begin
            state_d = EMIT;
            count_d = '0;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST) begin
            state_d = COLLECT;
            count_d = '0;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      state_q   <= COLLECT;
      count_q   <= '0;
      exp_max_q <= '0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      exp_max_q <= exp_max_d;
      mode_q    <= mode_d;
    end
  end

  // Buffer contents are only observed in EMIT, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      opbuf_q[count_q] <= in_data;
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == EMIT);
  assign out_last  = (state_q == EMIT) && (count_q == LAST);
  assign out_data  = (state_q != EMIT) ? '0 : (mode_q ? aligned : cur_op);
  assign exp_max   = mode_q ? exp_max_q : '0;

endmodule

// File: tb/tb_fp_prealign.sv
// Self-checking bench for fp_prealign: directed block table, reset abort, random blocks.
module tb_fp_prealign;
  import cim_fp_pkg::*;

  typedef logic [0:7][7:0] blk_t;
  typedef struct packed {
    logic       fp;
    blk_t       din;
    blk_t       dout;
    logic [4:0] emax;
    logic [3:0] stall;
  } vec_t;

  logic             clk = 1'b0;
  logic             RSTN = 1'b0;
  logic             InFp = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             out_ready = 1'b0;
  logic             in_ready, out_valid, out_last;
  logic [OUT_W-1:0] out_data;
  logic [EXP_W-1:0] exp_max;

  int checks = 0;
  int failures = 0;
  vec_t tbl [7];

  always #5 clk = ~clk;

  fp_prealign #(.N(8)) dut (
    .clk       (clk),
    .RSTN      (RSTN),
    .InFp      (InFp),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .exp_max   (exp_max)
  );

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Reference: value = (1.mant * 64) / 2^(emax-exp), truncated, signed.
  function automatic int ref_align(input logic [7:0] d, input int emax);
    int e, m, mag;
    e = int'(d[6:2]);
    m = int'(d[1:0]);
    if (e == 0) return 0;
    mag = (4 + m) * 16;
    if (emax - e >= 7) mag = 0;
    else mag = mag / (1 << (emax - e));
    return d[7] ? -mag : mag;
  endfunction

  function automatic int ref_emax(input blk_t b);
    int m = 0;
    for (int i = 0; i < 8; i++)
      if (int'(b[i][6:2]) > m) m = int'(b[i][6:2]);
    return m;
  endfunction

  function automatic blk_t ref_block(input logic fp, input blk_t b);
    blk_t r;
    int em = ref_emax(b);
    for (int i = 0; i < 8; i++)
      r[i] = fp ? 8'(ref_align(b[i], em)) : b[i];
    return r;
  endfunction

  task automatic check_out(input string nm, input blk_t dout, input int emax, input int j);
    check({nm, " out_valid"}, int'(out_valid), 1);
    check({nm, " out_data"}, int'($signed(out_data)), int'($signed(dout[j])));
    check({nm, " out_last"}, int'(out_last), (j == 7) ? 1 : 0);
    check({nm, " exp_max"}, int'(exp_max), emax);
    check({nm, " in_ready low"}, int'(in_ready), 0);
  endtask

  // Called and returns at a negedge.
  task automatic run_block(input string nm, input logic fp, input blk_t din,
                           input blk_t dout, input int emax, input int stall);
    for (int i = 0; i < 8; i++) begin
      check({nm, " in_ready"}, int'(in_ready), 1);
      check({nm, " no early out_valid"}, int'(out_valid), 0);
      InFp     = (i == 0) ? fp : ~fp;
      in_valid = 1'b1;
      in_data  = din[i];
      @(posedge clk); @(negedge clk);
    end
    for (int j = 0; j < 8; j++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      if (j == stall) begin
        out_ready = 1'b0;
        repeat (3) begin
          check_out({nm, " stall"}, dout, emax, j);
          @(posedge clk); @(negedge clk);
        end
      end
      out_ready = 1'b1;
      check_out(nm, dout, emax, j);
      @(posedge clk); @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({nm, " in_ready after block"}, int'(in_ready), 1);
    check({nm, " out_valid after block"}, int'(out_valid), 0);
  endtask

  initial begin
    blk_t b, r;
    int   base, st;
    logic fp;

    tbl[0] = '{1'b1, {8'h40, 8'h3C, 8'hBE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                     {8'h40, 8'h20, 8'hD0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5'd16, 4'hF};
    tbl[1] = '{1'b1, {8'h78, 8'h04, 8'h64, 8'h60, 8'h5C, 8'h00, 8'h00, 8'h00},
                     {8'h40, 8'h00, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}, 5'd30, 4'hF};
    tbl[2] = '{1'b1, {8'hF8, 8'h84, 8'hE4, 8'hE0, 8'hDC, 8'h00, 8'h00, 8'h00},
                     {8'hC0, 8'h00, 8'hFE, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, 5'd30, 4'hF};
    tbl[3] = '{1'b0, {8'h85, 8'h7F, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h10, 8'hF0},
                     {8'h85, 8'h7F, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h10, 8'hF0}, 5'd0, 4'hF};
    tbl[4] = '{1'b1, {8'h40, 8'h3C, 8'hBE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                     {8'h40, 8'h20, 8'hD0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5'd16, 4'd2};
    tbl[5] = '{1'b1, {8'h00, 8'h80, 8'h03, 8'h81, 8'h02, 8'h83, 8'h00, 8'h80},
                     {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5'd0, 4'hF};
    tbl[6] = '{1'b1, {8'h7F, 8'hFF, 8'h7B, 8'h7C, 8'h80, 8'h06, 8'h6B, 8'hEB},
                     {8'h70, 8'h90, 8'h38, 8'h40, 8'h00, 8'h00, 8'h03, 8'hFD}, 5'd31, 4'd7};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", int'(in_ready), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_last", int'(out_last), 0);
    check("reset out_data", int'(out_data), 0);
    check("reset exp_max", int'(exp_max), 0);
    RSTN = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      run_block($sformatf("tbl%0d", k), tbl[k].fp, tbl[k].din, tbl[k].dout,
                int'(tbl[k].emax), (tbl[k].stall == 4'hF) ? -1 : int'(tbl[k].stall));
    end

    // Abort a block part-way: 5 high-exponent operands then reset.
    for (int i = 0; i < 5; i++) begin
      InFp = 1'b1; in_valid = 1'b1; in_data = 8'h7C;
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    RSTN = 1'b0;
    @(posedge clk); @(negedge clk);
    RSTN = 1'b1;
    check("midreset out_valid", int'(out_valid), 0);
    check("midreset in_ready", int'(in_ready), 1);
    check("midreset exp_max", int'(exp_max), 0);
    check("midreset out_data", int'(out_data), 0);
    b = {8'h3C, 8'h38, 8'hB9, 8'h00, 8'h3A, 8'h35, 8'h2C, 8'h84};
    r = ref_block(1'b1, b);
    run_block("post_reset", 1'b1, b, r, ref_emax(b), -1);
    check("post_reset emax model", ref_emax(b), 15);

    for (int n = 0; n < 24; n++) begin
      fp   = 1'($urandom_range(0, 1));
      base = $urandom_range(8, 31);
      for (int i = 0; i < 8; i++) begin
        if (n % 2 == 0) b[i] = 8'($urandom);
        else b[i] = {1'($urandom), 5'(base - $urandom_range(0, 8)), 2'($urandom)};
      end
      r  = ref_block(fp, b);
      st = $urandom_range(0, 11);
      run_block($sformatf("rand%0d", n), fp, b, r, fp ? ref_emax(b) : 0,
                (st < 8) ? st : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
